mod_47: RTL and testbench

MOD_47 -- requirements
Module: mod_47

---
 rtl/mod_47_pkg.sv | 9 +
 rtl/mod_47_wrap.sv | 27 ++
 rtl/mod_47.sv | 36 +++
 tb/tb_mod_47.sv | 117 +++++++++++
 4 files changed

// File: rtl/mod_47_pkg.sv
// Shared constants for the modulo-47 counter slice.
// The counter runs 0..MAX and wraps back to 0.
package mod_47_pkg;

  localparam int MODULUS = 47;
  localparam int WIDTH   = 6;
  localparam int MAX     = MODULUS - 1;

endpackage

// File: rtl/mod_47_wrap.sv
// Combinational modulo helpers for the counter.
// inc is (cur+1) mod MODULUS; norm folds a raw load value into 0..MODULUS-1.
module mod_47_wrap #(
  parameter int MODULUS = mod_47_pkg::MODULUS,
  parameter int WIDTH   = mod_47_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] inc,
  output logic [WIDTH-1:0] norm
);

  // One extra bit so MODULUS == 2**WIDTH is still representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] raw_ext;

  // A single conditional subtract suffices because a WIDTH-bit value is
  // always below 2*MODULUS for the supported parameter range.
  always_comb begin
    raw_ext = {1'b0, raw};
    inc     = (cur == MAX_VAL) ? '0 : cur + 1'b1;
    norm    = (raw_ext >= MOD_EXT) ? WIDTH'(raw_ext - MOD_EXT) : raw;
  end

endmodule

// File: rtl/mod_47.sv
// Modulo-47 counter with synchronous reset and parallel load.
// Priority at each edge: rst, then load, then increment.
module mod_47 #(
  parameter int MODULUS = mod_47_pkg::MODULUS,
  parameter int WIDTH   = mod_47_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] load_norm;

  mod_47_wrap #(
    .MODULUS(MODULUS),
    .WIDTH  (WIDTH)
  ) u_wrap (
    .cur (count),
    .raw (in),
    .inc (count_inc),
    .norm(load_norm)
  );

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_norm;
    else
      count <= count_inc;
  end

endmodule

// File: tb/tb_mod_47.sv
// Scoreboard bench for mod_47: stimulus pushes expected counts, a monitor
// pops one expectation per rising edge and compares it against count.
module tb_mod_47;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       load;
  logic [5:0] in_v;
  logic [5:0] count;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mod_47 #(
    .MODULUS(47),
    .WIDTH  (6)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .in   (in_v),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: count=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge; the expectation applies after the next rising edge.
  task automatic applyStimulus(input logic r, input logic l, input logic [5:0] v,
                               input logic [5:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    rst  = r;
    load = l;
    in_v = v;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e.name, count, e.exp);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    in_v = 6'd0;

    applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, "reset");
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd1, "after_reset_1");
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd2, "after_reset_2");
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd3, "after_reset_3");

    applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, "wrap_reset");
    for (int i = 1; i <= 46; i++)
      applyStimulus(1'b0, 1'b0, 6'd0, 6'(i), "wrap_run");
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, "wrap_46_to_0");
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd1, "wrap_edge48");

    applyStimulus(1'b0, 1'b1, 6'd4, 6'd4, "load_4");
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd5, "load_4_inc1");
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd6, "load_4_inc2");
    applyStimulus(1'b0, 1'b1, 6'd46, 6'd46, "load_46");
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, "load_46_wrap");
    applyStimulus(1'b0, 1'b1, 6'd0, 6'd0, "load_0");

    applyStimulus(1'b0, 1'b1, 6'd47, 6'd0, "load_47");
    applyStimulus(1'b0, 1'b1, 6'd50, 6'd3, "load_50");
    applyStimulus(1'b0, 1'b1, 6'd63, 6'd16, "load_63");
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd17, "load_63_inc");

    applyStimulus(1'b1, 1'b1, 6'd10, 6'd0, "rst_over_load");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 6'd9, 6'd9, "load_hold_9");

    applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, "mid_prep_reset");
    for (int i = 1; i <= 30; i++)
      applyStimulus(1'b0, 1'b0, 6'd0, 6'(i), "mid_run");
    applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, "mid_reset_at_30");
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd1, "mid_resume");

    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
